// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the 1-to-2 buffered demultiplexer.
//   WIDTH_DEFAULT : default data word width
//   DEPTH_DEFAULT : default entries per output FIFO (power of two, >= 2)
//   STAT_W        : width of the optional per-port accept counters
//   port_idx_t    : 1-bit output port index
// ---------------------------------------------------------------------------
package demux_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int DEPTH_DEFAULT = 2;
    localparam int STAT_W        = 16;

    typedef logic [0:0] port_idx_t;

endpackage : demux_pkg

// File: rtl/demux_fifo.sv
// ---------------------------------------------------------------------------
// demux_fifo
// Small synchronous FIFO used once per demux output port.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (clears storage too)
//   push        : write request; ignored while full (even if popped that cycle)
//   push_data   : word to write
//   pop         : read request; ignored while empty
//   full, empty : occupancy flags derived from the registered count
//   head_data   : oldest stored word, straight from storage
// ---------------------------------------------------------------------------
module demux_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Full is taken from the registered count only, so a full FIFO never
    // accepts a word in the same cycle it is popped.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            // DEPTH is a power of two, so natural overflow wraps the pointer.
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule : demux_fifo

// File: rtl/demux1to2_buf.sv
// ---------------------------------------------------------------------------
// demux1to2_buf
// 1-to-2 demultiplexer with a small FIFO and independent valid/ready
// handshake on each output port.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : producer handshake; in_ready = !full[in_sel]
//   in_sel                : destination port of the presented word
//   in_data               : presented word
//   outN_valid/outN_ready : consumer handshake for port N (N = 0, 1)
//   outN_data             : head word of port N FIFO
//   cnt0, cnt1            : (DEMUX_STATS_EN only) 16-bit wrapping counts of
//                           words accepted into each port
// Configuration macro: DEMUX_STATS_EN adds the per-port accept counters.
// ---------------------------------------------------------------------------
module demux1to2_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sel,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [WIDTH-1:0]  out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [WIDTH-1:0]  out1_data
`ifdef DEMUX_STATS_EN
    ,
    output logic [STAT_W-1:0] cnt0,
    output logic [STAT_W-1:0] cnt1
`endif
);

    logic [1:0]       fifo_push;
    logic [1:0]       fifo_pop;
    logic [1:0]       fifo_full;
    logic [1:0]       fifo_empty;
    logic [WIDTH-1:0] fifo_head [2];
    logic             accept;

    // Readiness depends only on the port the current word is headed for.
    assign in_ready = !fifo_full[in_sel];
    assign accept   = in_valid && in_ready;

    assign fifo_pop[0] = out0_ready;
    assign fifo_pop[1] = out1_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign fifo_push[gi] = accept && (port_idx_t'(in_sel) == port_idx_t'(gi));

            demux_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (fifo_push[gi]),
                .push_data (in_data),
                .pop       (fifo_pop[gi]),
                .full      (fifo_full[gi]),
                .empty     (fifo_empty[gi]),
                .head_data (fifo_head[gi])
            );
        end
    endgenerate

    assign out0_valid = !fifo_empty[0];
    assign out1_valid = !fifo_empty[1];
    assign out0_data  = fifo_head[0];
    assign out1_data  = fifo_head[1];

`ifdef DEMUX_STATS_EN
    logic [STAT_W-1:0] cnt_q [2];
    logic [STAT_W-1:0] cnt_d [2];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_stat
            // Natural overflow gives the 16'hFFFF -> 0 wrap.
            always_comb begin
                cnt_d[gi] = cnt_q[gi];
                if (fifo_push[gi]) begin
                    cnt_d[gi] = cnt_q[gi] + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q[gi] <= '0;
                end else begin
                    cnt_q[gi] <= cnt_d[gi];
                end
            end
        end
    endgenerate

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
`endif

endmodule : demux1to2_buf

// File: tb/tb_demux1to2_buf.sv
// ---------------------------------------------------------------------------
// tb_demux1to2_buf
// Directed bench for demux1to2_buf. Inputs change 1 time unit after a rising
// edge; outputs are examined before the next rising edge.
// ---------------------------------------------------------------------------
module tb_demux1to2_buf;
    import demux_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_sel;
    logic [W-1:0] in_data;
    logic         out0_valid;
    logic         out0_ready;
    logic [W-1:0] out0_data;
    logic         out1_valid;
    logic         out1_ready;
    logic [W-1:0] out1_data;
`ifdef DEMUX_STATS_EN
    logic [STAT_W-1:0] cnt0;
    logic [STAT_W-1:0] cnt1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    demux1to2_buf #(
        .WIDTH (W),
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef DEMUX_STATS_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
            $display("check %s obs=%0h exp=%0h ok", tag, obs, exp);
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = '0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #2;
        chk("rst_v0", {31'b0, out0_valid}, 0);
        chk("rst_v1", {31'b0, out1_valid}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Idle after reset
        chk("idle_v0", {31'b0, out0_valid}, 0);
        chk("idle_v1", {31'b0, out1_valid}, 0);
        chk("idle_d0", out0_data, 0);
        chk("idle_d1", out1_data, 0);
        chk("idle_rdy", {31'b0, in_ready}, 1);

        // Basic steering, both consumers ready
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 3;
        #1;
        chk("s1_rdy", {31'b0, in_ready}, 1);
        tick();
        chk("s1_v0", {31'b0, out0_valid}, 1);
        chk("s1_d0", out0_data, 3);
        chk("s1_v1", {31'b0, out1_valid}, 0);
        in_sel  = 1'b1;
        in_data = 5;
        tick();
        chk("s2_v0", {31'b0, out0_valid}, 0);
        chk("s2_v1", {31'b0, out1_valid}, 1);
        chk("s2_d1", out1_data, 5);
        in_valid = 1'b0;
        tick();
        chk("s3_v1", {31'b0, out1_valid}, 0);

        // Port 0 stall: fill it, blocked third push, port 1 still open
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 10;
        tick();
        in_data = 11;
        tick();
        in_data = 12;
        #1;
        chk("full0_rdy", {31'b0, in_ready}, 0);
        in_sel  = 1'b1;
        in_data = 20;
        #1;
        chk("sel1_rdy", {31'b0, in_ready}, 1);
        tick();
        chk("p20_v1", {31'b0, out1_valid}, 1);
        chk("p20_d1", out1_data, 20);
        chk("head10", out0_data, 10);
        in_sel     = 1'b0;
        in_data    = 12;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        #1;
        chk("full_pop_rdy", {31'b0, in_ready}, 0);
        tick();
        chk("head11", out0_data, 11);
        chk("after_full_rdy", {31'b0, in_ready}, 1);
        chk("p20_gone", {31'b0, out1_valid}, 0);
        tick();
        chk("head12", out0_data, 12);
        chk("head12_v", {31'b0, out0_valid}, 1);
        in_valid = 1'b0;
        tick();
        chk("drain0_v", {31'b0, out0_valid}, 0);

        // Port 1 at count 1: simultaneous push/pop, pointers wrap
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b1;
        in_data    = 100;
        tick();
        chk("c1_head", out1_data, 100);
        out1_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'(70 + i);
            #1;
            chk("pp_rdy", {31'b0, in_ready}, 1);
            tick();
            chk("pp_v1", {31'b0, out1_valid}, 1);
            chk("pp_d1", out1_data, 32'(70 + i));
        end
        in_valid = 1'b0;
        tick();
        chk("pp_drain", {31'b0, out1_valid}, 0);

        // Fill both FIFOs, then asynchronous reset mid-cycle
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 1;
        tick();
        in_data = 2;
        tick();
        in_sel  = 1'b1;
        in_data = 3;
        tick();
        in_data = 4;
        tick();
        in_valid = 1'b0;
        chk("both_full_rdy1", {31'b0, in_ready}, 0);
        in_sel = 1'b0;
        #1;
        chk("both_full_rdy0", {31'b0, in_ready}, 0);
        chk("both_d0", out0_data, 1);
        chk("both_d1", out1_data, 3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_v0", {31'b0, out0_valid}, 0);
        chk("arst_v1", {31'b0, out1_valid}, 0);
        chk("arst_d0", out0_data, 0);
        chk("arst_d1", out1_data, 0);
        tick();
        rst_n      = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        tick();
        tick();
        chk("post_v0", {31'b0, out0_valid}, 0);
        chk("post_v1", {31'b0, out1_valid}, 0);
        chk("post_d0", out0_data, 0);
        chk("post_d1", out1_data, 0);
        chk("post_rdy", {31'b0, in_ready}, 1);

`ifdef DEMUX_STATS_EN
        // 65537 accepts to port 1: counter wraps to 1
        chk("cnt1_zero", {16'b0, cnt1}, 0);
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 32'h55;
        for (int i = 0; i < 65537; i++) begin
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("cnt1_wrap", {16'b0, cnt1}, 1);
        chk("cnt0_zero", {16'b0, cnt0}, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_demux1to2_buf
